// File: rtl/adc_capture_ctrl_pkg.sv
// adc_capture_ctrl shared types and constants.
// State encoding, default widths and trigger slope codes.
package adc_capture_ctrl_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 10;
  localparam int RATE_W_DEF = 16;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_active(state_t s);
    return s inside {ST_PRE, ST_WAIT, ST_POST};
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Frame-engine handshake and sample-buffer write port.
// master = capture controller, slave = engine/buffer side.
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
);

  logic              adc_start;
  logic              adc_busy;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output adc_start,
    input  adc_busy,
    input  adc_valid,
    input  adc_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  adc_start,
    output adc_busy,
    output adc_valid,
    output adc_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/adc_trig_detect.sv
// Level/slope crossing detector on the returned sample stream.
// Keeps the previous sample; hit is combinational on the current one.
module adc_trig_detect
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] level,
  input  logic              slope,
  output logic              hit
);

  logic [DATA_W-1:0] prev;
  logic              pv;

  // Remember the last accepted sample; arm forgets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      pv   <= 1'b0;
    end else if (clr) begin
      pv   <= 1'b0;
    end else if (en) begin
      prev <= sample;
      pv   <= 1'b1;
    end
  end

  // Crossing needs a previous sample on the other side of level.
  always_comb begin
    hit = 1'b0;
    if (pv) begin
      unique case (slope)
        SLOPE_RISE: hit = (prev < level) && (level <= sample);
        SLOPE_FALL: hit = (prev > level) && (level >= sample);
        default:    hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Oscilloscope capture sequencer: paces ADC frames, triggers, fills ring.
// Define ADC_CAPTURE_AUTO_TRIG_EN to force a trigger after DEPTH waits.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [RATE_W-1:0] rate_div,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
  input  logic [ADDR_W-1:0] pretrig,
  adc_capture_ctrl_if.master bus,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done,
  output logic              overrun
);

  state_t            state;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] rcnt;
  logic [DATA_W-1:0] level_q;
  logic              slope_q;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] post_need;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   nxt_cnt;
  logic              active;
  logic              take_arm;
  logic              tick;
  logic              vld;
  logic              hit;
  logic              force_trig;
  logic              trig;

  assign active    = is_active(state);
  assign take_arm  = arm &&
                     (state == ST_IDLE || state == ST_DONE);
  assign tick      = active && (rcnt == rate_q);
  assign vld       = active && bus.adc_valid;
  assign nxt_cnt   = cnt + 1'b1;
  // pretrig's width already caps it at DEPTH-1,
  // so ~pre_q is DEPTH-1-pretrig without underflow.
  assign post_need = ~pre_q;

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
  localparam logic [ADDR_W:0] DEPTH_C =
    {1'b1, {ADDR_W{1'b0}}};
  assign force_trig = (nxt_cnt == DEPTH_C);
`else
  assign force_trig = 1'b0;
`endif

  assign trig = hit || force_trig;

  adc_trig_detect #(
    .DATA_W (DATA_W)
  ) u_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (take_arm),
    .en     (vld),
    .sample (bus.adc_data),
    .level  (level_q),
    .slope  (slope_q),
    .hit    (hit)
  );

  // Capture FSM, rate counter and registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rate_q        <= '0;
      rcnt          <= '0;
      level_q       <= '0;
      slope_q       <= SLOPE_RISE;
      pre_q         <= '0;
      ptr           <= '0;
      cnt           <= '0;
      bus.adc_start <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      trig_addr     <= '0;
      capture_done  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      bus.adc_start <= 1'b0;
      bus.wr_en     <= 1'b0;
      if (take_arm) begin
        rate_q       <= rate_div;
        level_q      <= trig_level;
        slope_q      <= trig_slope;
        pre_q        <= pretrig;
        rcnt         <= '0;
        ptr          <= '0;
        cnt          <= '0;
        bus.wr_addr  <= '0;
        capture_done <= 1'b0;
        overrun      <= 1'b0;
        state        <= (pretrig == '0) ? ST_WAIT : ST_PRE;
      end else begin
        if (active) begin
          rcnt <= tick ? '0 : rcnt + 1'b1;
          if (tick) begin
            if (bus.adc_busy) overrun <= 1'b1;
            else bus.adc_start <= 1'b1;
          end
        end
        if (vld) begin
          bus.wr_en   <= 1'b1;
          bus.wr_data <= bus.adc_data;
          bus.wr_addr <= ptr;
          ptr         <= ptr + 1'b1;
        end
        unique case (state)
          ST_IDLE: ;
          ST_PRE: begin
            if (vld) begin
              if (nxt_cnt == {1'b0, pre_q}) begin
                cnt   <= '0;
                state <= ST_WAIT;
              end else begin
                cnt <= nxt_cnt;
              end
            end
          end
          ST_WAIT: begin
            if (vld) begin
              if (trig) begin
                trig_addr <= ptr;
                cnt       <= '0;
                state     <= (post_need == '0) ? ST_DONE : ST_POST;
              end else begin
                cnt <= nxt_cnt;
              end
            end
          end
          ST_POST: begin
            if (vld) begin
              if (nxt_cnt == {1'b0, post_need}) begin
                cnt   <= '0;
                state <= ST_DONE;
              end else begin
                cnt <= nxt_cnt;
              end
            end
          end
          ST_DONE: capture_done <= 1'b1;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
